// File: rtl/ticket_change_dispenser.sv
// Ticket/change dispenser: pulses one ticket per count, then pays change greedily (50/10/5/1) over a coin handshake.
// Optional per-denomination coin inventory is enabled with `define COIN_INVENTORY_EN.
`timescale 1ns/1ps
module ticket_change_dispenser #(
    parameter int TICKET_W = 3,
    parameter int AMT_W    = 8,
    parameter int CNT_W    = 8,
    parameter int INIT_50  = 8,
    parameter int INIT_10  = 8,
    parameter int INIT_5   = 8,
    parameter int INIT_1   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [TICKET_W-1:0] req_tickets,
    input  logic [AMT_W-1:0]    req_change,
    output logic                ticket_pulse,
    output logic                coin_valid,
    input  logic                coin_ready,
    output logic [5:0]          coin_value,
    output logic                done,
    output logic                short_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TICKET = 2'd1;
    localparam logic [1:0] S_CHANGE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          r_state;
    logic [TICKET_W-1:0] r_tix;
    logic [AMT_W-1:0]    r_rem;

    logic [3:0]       w_avail;
    logic [3:0]       w_sel;
    logic [5:0]       w_coin;
    logic             w_has_coin;
    logic             w_hs;
    logic [AMT_W-1:0] w_rem_next;

    // Greedy pick over stocked denominations; bit 3..0 select 50, 10, 5, 1.
    function automatic logic [3:0] pick_coin(input logic [AMT_W-1:0] rem, input logic [3:0] avail);
        int r;
        r = int'(rem);
        pick_coin = 4'b0000;
        if (avail[3] && r >= 50)      pick_coin = 4'b1000;
        else if (avail[2] && r >= 10) pick_coin = 4'b0100;
        else if (avail[1] && r >= 5)  pick_coin = 4'b0010;
        else if (avail[0] && r >= 1)  pick_coin = 4'b0001;
    endfunction

    always_comb begin
        w_sel      = pick_coin(r_rem, w_avail);
        w_has_coin = |w_sel;
        w_coin     = w_sel[3] ? 6'd50 :
                     w_sel[2] ? 6'd10 :
                     w_sel[1] ? 6'd5  :
                     w_sel[0] ? 6'd1  : 6'd0;
        coin_valid = (r_state == S_CHANGE) && w_has_coin;
        coin_value = coin_valid ? w_coin : 6'd0;
        w_hs       = coin_valid && coin_ready;
        w_rem_next = r_rem - AMT_W'(w_coin);
    end

    assign req_ready    = (r_state == S_IDLE);
    assign ticket_pulse = (r_state == S_TICKET);
    assign done         = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tix   <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_tix <= req_tickets;
                        r_rem <= req_change;
                        if (req_tickets != '0)     r_state <= S_TICKET;
                        else if (req_change != '0) r_state <= S_CHANGE;
                        else                       r_state <= S_DONE;
                    end
                end
                S_TICKET: begin
                    r_tix <= r_tix - TICKET_W'(1);
                    if (r_tix == TICKET_W'(1))
                        r_state <= (r_rem != '0) ? S_CHANGE : S_DONE;
                end
                S_CHANGE: begin
                    if (w_hs) begin
                        r_rem <= w_rem_next;
                        if (w_rem_next == '0) r_state <= S_DONE;
                    end else if (!w_has_coin) begin
                        // Nothing stocked fits the remainder: give up on it.
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef COIN_INVENTORY_EN
    logic             r_short;
    logic [CNT_W-1:0] r_inv [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_short  <= 1'b0;
            r_inv[3] <= CNT_W'(INIT_50);
            r_inv[2] <= CNT_W'(INIT_10);
            r_inv[1] <= CNT_W'(INIT_5);
            r_inv[0] <= CNT_W'(INIT_1);
        end else begin
            if (r_state == S_IDLE && req_valid)
                r_short <= 1'b0;
            else if (r_state == S_CHANGE && !w_has_coin)
                r_short <= 1'b1;
            for (int i = 0; i < 4; i++)
                if (w_hs && w_sel[i] && r_inv[i] != '0)
                    r_inv[i] <= r_inv[i] - CNT_W'(1);
        end
    end

    assign w_avail   = {r_inv[3] != '0, r_inv[2] != '0, r_inv[1] != '0, r_inv[0] != '0};
    assign short_err = done && r_short;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{CNT_W, INIT_50, INIT_10, INIT_5, INIT_1};
    assign w_avail      = 4'b1111;
    assign short_err    = 1'b0;
`endif

endmodule
